imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Decode-stage controller that accepts fetched LoongArch instructions over a valid/ready handshake and holds each one in a decode register. It classifies the instruction's immediate format, drives the shared combinational sign-extension unit (`sext_op`/`sext_din`) and captures the extended immediate and branch target into an execute-facing output register. It sits between the IF stage and the EX stage of the pipelined core, and handles backpressure and flush.

## Interface
- `RESET_PC`, default 32'h1C00_0000: reset value of the held `ex_pc`.
- `cpu_clk` in 1: clock; all state updates on the rising edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `if_valid` in 1: IF presents an instruction.
- `if_inst` in 32: instruction word.
- `if_pc` in 32: instruction PC.
- `id_ready` out 1: decode register can accept this cycle (combinational).
- `flush` in 1: kill all in-flight entries (branch redirect or exception).
- `sext_op` out 3: extension-unit operation code.
- `sext_din` out 26: extension-unit data input.
- `sext_ext` in 32: extension-unit result (combinational return).
- `ex_valid` out 1: output register holds a valid entry.
- `ex_ready` in 1: EX consumes the entry this cycle.
- `ex_inst` out 32: instruction word of the entry.
- `ex_pc` out 32: PC of the entry.
- `ex_imm` out 32: extended immediate.
- `ex_imm_vld` out 1: instruction carries an immediate.
- `ex_is_br` out 1: PC-relative branch or jump (b, bl, beq..bgeu).
- `ex_target` out 32: `ex_pc + ex_imm`, valid when `ex_is_br`.

## Operation
- **Operation codes:** I5=0, I12=1, I12U=2, I20=3, I16=4, I26=5, NONE=7. For NONE the extension unit returns 0.
- **Decode**, from the ID register instruction `i`:
  - I5: `i[31:15]` ∈ {0x00081, 0x00089, 0x00091} (slli/srli/srai.w).
  - I12: `i[31:22]` ∈ {0x008, 0x009, 0x00A, 0x0A0, 0x0A1, 0x0A2, 0x0A4, 0x0A5, 0x0A6, 0x0A8, 0x0A9}.
  - I12U: `i[31:22]` ∈ {0x00D, 0x00E, 0x00F}.
  - I20: `i[31:25]` ∈ {7'b0001010, 7'b0001110}.
  - I16: `i[31:26]` ∈ {0x13, 0x16 to 0x1B}.
  - I26: `i[31:26]` ∈ {0x14, 0x15}.
  - Anything else decodes as NONE, with `ex_imm_vld`=0.
- `ex_is_br` is set for opcodes 0x14 to 0x1B, excluding jirl (0x13).
- `sext_din` = `i[25:0]` at all times. `sext_op` is driven from the decoded class whenever `id_vld`=1; otherwise it is NONE.
- **Two-entry pipeline:**
  - ID register: `id_vld`, `id_inst`, `id_pc`.
  - Output register: `ex_*`.
  - `ex_adv` = `!ex_valid || ex_ready`.
  - `id_ready` = `!flush && (!id_vld || ex_adv)`.
- **ID to EX transfer** when `id_vld && ex_adv && !flush`:
  - Capture `sext_ext` into `ex_imm`, plus the class flags.
  - `ex_target` = `id_pc + sext_ext`, computed mod 2^32 with wrap ignored.
- **IF to ID transfer** when `if_valid && id_ready`.
- When `ex_ready && ex_valid` and no new transfer occurs, `ex_valid` clears. Data fields then hold their last value.
- **flush:** on that edge `id_vld` and `ex_valid` both clear. `if_valid` in the same cycle is not accepted, because `id_ready` is 0.
- **Reset:**
  - `id_vld`=0, `ex_valid`=0.
  - `ex_inst`, `ex_imm`, `ex_target` = 0; `ex_pc` = `RESET_PC`.
  - `ex_imm_vld`=0, `ex_is_br`=0.
  - `sext_op` = NONE.
- Reset has priority over flush, and flush has priority over every transfer.
- **Stalled entries:** while `ex_valid && !ex_ready`, all `ex_*` outputs are held stable. The ID entry also holds, and `id_ready` is 0 if `id_vld` is set.

## Timing
- An instruction accepted at edge N is in ID during cycle N+1, when `sext_op` is valid. With no backpressure it appears on `ex_*` with `ex_valid`=1 from cycle N+2.
- Throughput is one instruction per cycle with continuous `ex_ready`=1.
- `id_ready` depends combinationally on `ex_ready` and `flush`. There are no combinational paths from `if_*` to any output.
- **Simultaneous EX consume and ID transfer:** the output register reloads and `ex_valid` stays 1.
- **Simultaneous IF accept and ID-to-EX transfer:** the ID register reloads and `id_vld` stays 1. No bubble.
- **Reset mid-stall:** all entries are dropped. `ex_valid`=0 and `id_ready`=1 in the next cycle.

## Test plan
- **addi.w `0x02BFFC01`, `if_pc` `0x1C000000`, `ex_ready`=1:** `sext_op`=1 in cycle N+1. Cycle N+2 shows `ex_imm`=`0xFFFFFFFF`, `ex_imm_vld`=1, `ex_is_br`=0.
- **Back-to-back ori `0x03BFFC01` then lu12i.w `0x15000001`:** consecutive cycles give `ex_imm` `0x00000FFF` then `0x80000000`, with `ex_valid` held high and no bubble.
- **b `0x53FFFFFF` at pc `0x1C000010`:** `sext_op`=5, `ex_imm`=`0xFFFFFFFC`, `ex_is_br`=1, `ex_target`=`0x1C00000C`.
- **beq `0x58001000` at pc `0x1C000000`, `ex_ready`=0 for 3 cycles:** `ex_imm`=`0x10` and `ex_target`=`0x1C000010` are held stable. A second instruction fills ID, then `id_ready`=0 until `ex_ready` rises. Both entries emerge in order.
- **flush asserted with both registers full and `if_valid`=1:** next cycle `ex_valid`=0, `id_vld`=0, and the IF word is not accepted. A following instruction takes the normal 2-cycle latency.
- **Unrecognized word `0xFFFFFFFF`:** `sext_op`=7, `ex_imm`=0, `ex_imm_vld`=0, `ex_is_br`=0. `cpu_rst` asserted mid-stall returns every output to its reset value.

Source files
------------

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_decode_stage
//  Purpose  : LoongArch decode-stage controller. Holds one fetched
//             instruction in an ID register, classifies its immediate
//             format and drives the shared sign-extension unit. It then
//             captures the extended immediate and the branch target into
//             an EX-facing output register. Valid/ready handshake on both
//             sides; flush kills both entries.
//  Ports    : cpu_clk/cpu_rst       clock, synchronous active-high reset
//             if_valid/if_inst/if_pc/id_ready   fetch-side handshake
//             flush                 kill all in-flight entries
//             sext_op/sext_din/sext_ext  extension-unit request/result
//             ex_valid/ex_ready     execute-side handshake
//             ex_inst/ex_pc/ex_imm/ex_imm_vld/ex_is_br/ex_target  EX entry
//  Revision : 1.0  initial release
// ============================================================================
module imm_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  output logic [2:0]  sext_op,
  output logic [25:0] sext_din,
  input  logic [31:0] sext_ext,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic        ex_imm_vld,
  output logic        ex_is_br,
  output logic [31:0] ex_target
);

  localparam logic [2:0] c_op_i5   = 3'd0;
  localparam logic [2:0] c_op_i12  = 3'd1;
  localparam logic [2:0] c_op_i12u = 3'd2;
  localparam logic [2:0] c_op_i20  = 3'd3;
  localparam logic [2:0] c_op_i16  = 3'd4;
  localparam logic [2:0] c_op_i26  = 3'd5;
  localparam logic [2:0] c_op_none = 3'd7;

  logic        r_id_vld;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;

  logic [2:0]  w_cls;
  logic        w_is_br;
  logic        w_ex_adv;
  logic        w_id_to_ex;
  logic        w_if_to_id;

  // Immediate-format classification of the instruction held in ID.
  always_comb begin
    w_cls = c_op_none;
    if (r_id_inst[31:15] inside {17'h00081, 17'h00089, 17'h00091}) begin
      w_cls = c_op_i5;
    end else if (r_id_inst[31:22] inside {10'h008, 10'h009, 10'h00A,
                                          10'h0A0, 10'h0A1, 10'h0A2,
                                          10'h0A4, 10'h0A5, 10'h0A6,
                                          10'h0A8, 10'h0A9}) begin
      w_cls = c_op_i12;
    end else if (r_id_inst[31:22] inside {10'h00D, 10'h00E, 10'h00F}) begin
      w_cls = c_op_i12u;
    end else if (r_id_inst[31:25] inside {7'b0001010, 7'b0001110}) begin
      w_cls = c_op_i20;
    end else if (r_id_inst[31:26] == 6'h13 ||
                 (r_id_inst[31:26] >= 6'h16 && r_id_inst[31:26] <= 6'h1B)) begin
      w_cls = c_op_i16;
    end else if (r_id_inst[31:26] inside {6'h14, 6'h15}) begin
      w_cls = c_op_i26;
    end
  end

  // PC-relative control transfers: b, bl and the conditional branches; jirl
  // (0x13) is register-relative and therefore excluded.
  assign w_is_br = (r_id_inst[31:26] >= 6'h14) && (r_id_inst[31:26] <= 6'h1B);

  assign sext_op  = r_id_vld ? w_cls : c_op_none;
  assign sext_din = r_id_inst[25:0];

  assign w_ex_adv   = !ex_valid || ex_ready;
  assign id_ready   = !flush && (!r_id_vld || w_ex_adv);
  assign w_id_to_ex = r_id_vld && w_ex_adv && !flush;
  assign w_if_to_id = if_valid && id_ready;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_id_vld   <= 1'b0;
      r_id_inst  <= 32'd0;
      r_id_pc    <= 32'd0;
      ex_valid   <= 1'b0;
      ex_inst    <= 32'd0;
      ex_pc      <= RESET_PC;
      ex_imm     <= 32'd0;
      ex_imm_vld <= 1'b0;
      ex_is_br   <= 1'b0;
      ex_target  <= 32'd0;
    end else if (flush) begin
      r_id_vld <= 1'b0;
      ex_valid <= 1'b0;
    end else begin
      // Output register: reload, or drop the entry once EX consumes it.
      // Data fields keep their last value when the entry drains.
      if (w_id_to_ex) begin
        ex_valid   <= 1'b1;
        ex_inst    <= r_id_inst;
        ex_pc      <= r_id_pc;
        ex_imm     <= sext_ext;
        ex_imm_vld <= (w_cls != c_op_none);
        ex_is_br   <= w_is_br;
        ex_target  <= r_id_pc + sext_ext;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end

      // ID register: a new fetch takes priority so a simultaneous
      // ID-to-EX move and IF accept leave no bubble.
      if (w_if_to_id) begin
        r_id_vld  <= 1'b1;
        r_id_inst <= if_inst;
        r_id_pc   <= if_pc;
      end else if (w_id_to_ex) begin
        r_id_vld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_decode_stage
//  Purpose  : Self-checking bench for imm_decode_stage. Provides the
//             sign-extension unit, a queue-based reference model, directed
//             scenarios with literal expectations and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic [2:0]  sext_op;
  logic [25:0] sext_din;
  logic [31:0] sext_ext;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_imm_vld;
  logic        ex_is_br;
  logic [31:0] ex_target;

  imm_decode_stage #(.RESET_PC(RESET_PC)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .id_ready  (id_ready),
    .flush     (flush),
    .sext_op   (sext_op),
    .sext_din  (sext_din),
    .sext_ext  (sext_ext),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_inst   (ex_inst),
    .ex_pc     (ex_pc),
    .ex_imm    (ex_imm),
    .ex_imm_vld(ex_imm_vld),
    .ex_is_br  (ex_is_br),
    .ex_target (ex_target)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  // Shared sign-extension unit living outside the decode stage.
  function automatic logic [31:0] ext_unit(input logic [2:0] op, input logic [25:0] d);
    case (op)
      3'd0:    return {27'd0, d[14:10]};
      3'd1:    return {{20{d[21]}}, d[21:10]};
      3'd2:    return {20'd0, d[21:10]};
      3'd3:    return {d[24:5], 12'd0};
      3'd4:    return {{14{d[25]}}, d[25:10], 2'b00};
      3'd5:    return {{4{d[9]}}, d[9:0], d[25:10], 2'b00};
      default: return 32'd0;
    endcase
  endfunction

  assign sext_ext = ext_unit(sext_op, sext_din);

  // ---------------- reference model (instruction-level) ----------------
  function automatic int cls_of(input logic [31:0] x);
    logic [9:0] t10;
    logic [5:0] op6;
    t10 = x[31:22];
    op6 = x[31:26];
    if (x[31:15] == 17'h00081 || x[31:15] == 17'h00089 || x[31:15] == 17'h00091) return 0;
    if (t10 == 10'h008 || t10 == 10'h009 || t10 == 10'h00A ||
        (t10 >= 10'h0A0 && t10 <= 10'h0A2) || (t10 >= 10'h0A4 && t10 <= 10'h0A6) ||
        t10 == 10'h0A8 || t10 == 10'h0A9) return 1;
    if (t10 >= 10'h00D && t10 <= 10'h00F) return 2;
    if (x[31:25] == 7'b0001010 || x[31:25] == 7'b0001110) return 3;
    if (op6 == 6'h13 || (op6 >= 6'h16 && op6 <= 6'h1B)) return 4;
    if (op6 == 6'h14 || op6 == 6'h15) return 5;
    return 7;
  endfunction

  // Immediate value computed with plain integer arithmetic.
  function automatic logic [31:0] exp_imm(input logic [31:0] x);
    longint v;
    longint u;
    u = longint'(x);
    v = 0;
    case (cls_of(x))
      0: v = (u >> 10) % 32;
      1: begin v = (u >> 10) % 4096; if (v >= 2048) v = v - 4096; end
      2: v = (u >> 10) % 4096;
      3: v = ((u >> 5) % 1048576) * 4096;
      4: begin v = (u >> 10) % 65536; if (v >= 32768) v = v - 65536; v = v * 4; end
      5: begin
        v = (u % 1024) * 65536 + (u >> 10) % 65536;
        if (v >= 33554432) v = v - 67108864;
        v = v * 4;
      end
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];          // accepted, waiting in decode
  logic        m_out_valid;
  logic [31:0] m_inst, m_pc, m_imm, m_target;
  logic        m_imm_vld, m_is_br;
  bit          checking;

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out_valid = 1'b0;
    m_inst = 32'd0; m_pc = RESET_PC; m_imm = 32'd0; m_target = 32'd0;
    m_imm_vld = 1'b0; m_is_br = 1'b0;
  endtask

  initial begin
    model_reset();
    checking = 0;
    n_cmp = 0;
    n_bad = 0;
  end

  // Compare against the model mid-cycle, then advance the model across
  // the coming rising edge using the now-stable inputs.
  always @(negedge cpu_clk) begin
    logic e_ready;
    ent_t e;
    int   k;
    e_ready = !flush && (m_q.size() == 0 || !m_out_valid || ex_ready);
    if (checking) begin
      chk("ex_valid", 32'(ex_valid), 32'(m_out_valid));
      chk("id_ready", 32'(id_ready), 32'(e_ready));
      chk("sext_op", 32'(sext_op), (m_q.size() != 0) ? 32'(cls_of(m_q[0].inst)) : 32'd7);
      if (m_q.size() != 0) chk("sext_din", 32'(sext_din), 32'(m_q[0].inst[25:0]));
      chk("ex_inst", ex_inst, m_inst);
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_imm_vld", 32'(ex_imm_vld), 32'(m_imm_vld));
      chk("ex_is_br", 32'(ex_is_br), 32'(m_is_br));
      chk("ex_target", ex_target, m_target);
    end
    if (cpu_rst) begin
      model_reset();
    end else if (flush) begin
      m_q.delete();
      m_out_valid = 1'b0;
    end else begin
      if (m_q.size() != 0 && (!m_out_valid || ex_ready)) begin
        e = m_q.pop_front();
        k = cls_of(e.inst);
        m_out_valid = 1'b1;
        m_inst = e.inst;
        m_pc = e.pc;
        m_imm = exp_imm(e.inst);
        m_imm_vld = (k != 7);
        m_is_br = (e.inst[31:26] >= 6'h14 && e.inst[31:26] <= 6'h1B);
        m_target = e.pc + m_imm;
      end else if (ex_ready) begin
        m_out_valid = 1'b0;
      end
      if (if_valid && e_ready) m_q.push_back('{inst: if_inst, pc: if_pc});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic rs);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    ex_ready = rdy;
    flush    = fl;
    cpu_rst  = rs;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'd0, 32'd0, rdy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: case ($urandom_range(0, 2))
           0: r[31:15] = 17'h00081;
           1: r[31:15] = 17'h00089;
           default: r[31:15] = 17'h00091;
         endcase
      1: case ($urandom_range(0, 10))
           0: r[31:22] = 10'h008;  1: r[31:22] = 10'h009;  2: r[31:22] = 10'h00A;
           3: r[31:22] = 10'h0A0;  4: r[31:22] = 10'h0A1;  5: r[31:22] = 10'h0A2;
           6: r[31:22] = 10'h0A4;  7: r[31:22] = 10'h0A5;  8: r[31:22] = 10'h0A6;
           9: r[31:22] = 10'h0A8;  default: r[31:22] = 10'h0A9;
         endcase
      2: r[31:22] = 10'h00D + 10'($urandom_range(0, 2));
      3: r[31:25] = ($urandom_range(0, 1) == 0) ? 7'b0001010 : 7'b0001110;
      4: r[31:26] = 6'h13 + 6'($urandom_range(0, 8));
      5: r[31:26] = 6'h14 + 6'($urandom_range(0, 1));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
    ex_ready = 1'b1; flush = 1'b0; cpu_rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checking = 1;
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst ex_pc", ex_pc, RESET_PC);
    chk("rst sext_op", 32'(sext_op), 32'd7);

    // addi.w
    drive(1'b1, 32'h02BFFC01, 32'h1C000000, 1'b1, 1'b0, 1'b0);
    chk("addi sext_op", 32'(sext_op), 32'd1);
    idle(1'b1);
    chk("addi ex_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi imm_vld", 32'(ex_imm_vld), 32'd1);
    chk("addi is_br", 32'(ex_is_br), 32'd0);
    idle(1'b1);

    // ori then lu12i.w back to back
    drive(1'b1, 32'h03BFFC01, 32'h1C000004, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h15000001, 32'h1C000008, 1'b1, 1'b0, 1'b0);
    chk("ori ex_imm", ex_imm, 32'h00000FFF);
    idle(1'b1);
    chk("lu12i ex_imm", ex_imm, 32'h80000000);
    chk("lu12i ex_valid", 32'(ex_valid), 32'd1);
    idle(1'b1);

    // b
    drive(1'b1, 32'h53FFFFFF, 32'h1C000010, 1'b1, 1'b0, 1'b0);
    chk("b sext_op", 32'(sext_op), 32'd5);
    idle(1'b1);
    chk("b ex_imm", ex_imm, 32'hFFFFFFFC);
    chk("b is_br", 32'(ex_is_br), 32'd1);
    chk("b target", ex_target, 32'h1C00000C);
    idle(1'b1);

    // beq with three stalled cycles and a second entry behind it
    drive(1'b1, 32'h58001000, 32'h1C000000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, 32'h02800401, 32'h1C000004, 1'b0, 1'b0, 1'b0);
    chk("beq stall imm", ex_imm, 32'h00000010);
    idle(1'b0);
    chk("beq stall target", ex_target, 32'h1C000010);
    idle(1'b0);
    chk("beq stall inst", ex_inst, 32'h58001000);
    chk("beq stall id_ready", 32'(id_ready), 32'd0);
    idle(1'b1);
    chk("beq second inst", ex_inst, 32'h02800401);
    idle(1'b1);

    // flush with both registers full
    drive(1'b1, 32'h02800801, 32'h1C000020, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h02800C01, 32'h1C000024, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h02801001, 32'h1C000028, 1'b0, 1'b1, 1'b0);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush sext_op", 32'(sext_op), 32'd7);
    idle(1'b1);
    chk("flush dropped", 32'(ex_valid), 32'd0);
    drive(1'b1, 32'h02801401, 32'h1C00002C, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("post flush inst", ex_inst, 32'h02801401);
    idle(1'b1);

    // unrecognized word, then reset mid-stall
    drive(1'b1, 32'hFFFFFFFF, 32'h1C000030, 1'b1, 1'b0, 1'b0);
    chk("none sext_op", 32'(sext_op), 32'd7);
    idle(1'b0);
    chk("none ex_imm", ex_imm, 32'd0);
    chk("none imm_vld", 32'(ex_imm_vld), 32'd0);
    drive(1'b1, 32'h02800401, 32'h1C000034, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("rst2 ex_valid", 32'(ex_valid), 32'd0);
    chk("rst2 ex_inst", ex_inst, 32'd0);
    chk("rst2 ex_pc", ex_pc, RESET_PC);
    cpu_rst = 1'b0;
    #1;
    chk("rst2 id_ready", 32'(id_ready), 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 70, gen_inst(), $urandom,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
            $urandom_range(0, 199) < 1);
    end
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
